// File: rtl/rf_write_scheduler_pkg.sv
// rtl/rf_write_scheduler_pkg.sv - shared constants and write-request type for the RF write scheduler
//
// Purpose: widths, the hardwired-zero register index and the {addr, data}
// write-request record carried through the MDU result buffer.
package rf_sched_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rf_write_scheduler_if.sv
// rtl/rf_write_scheduler_if.sv - MDU result handshake bundle
//
// Purpose: valid/ready transfer of one MDU result into the scheduler.
// Ports (signals):
//   mdu_valid  MDU result valid (held until accepted)
//   mdu_ready  scheduler can accept a result
//   mdu_addr   destination register
//   mdu_data   result value
// Modports: master = MDU side, slave = scheduler side.
interface rf_write_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              mdu_valid;
  logic              mdu_ready;
  logic [ADDR_W-1:0] mdu_addr;
  logic [DATA_W-1:0] mdu_data;

  modport master (
    output mdu_valid,
    output mdu_addr,
    output mdu_data,
    input  mdu_ready
  );

  modport slave (
    input  mdu_valid,
    input  mdu_addr,
    input  mdu_data,
    output mdu_ready
  );

endinterface

// File: rtl/rf_write_scheduler_fifo.sv
// rtl/rf_write_scheduler_fifo.sv - circular buffer of pending MDU register writes
//
// Purpose: DEPTH-entry FIFO of wr_req_t with full/empty flags and occupancy.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push_i        write push_data_i at posedge (ignored when full)
//   push_data_i   request to enqueue
//   pop_i         drop head at posedge (ignored when empty)
//   head_o        oldest entry, valid while !empty_o
//   full_o        count == DEPTH
//   empty_o       count == 0
//   count_o       number of buffered entries
module rf_wr_fifo
  import rf_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  wr_req_t                push_data_i,
  input  logic                   pop_i,
  output wr_req_t                head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  wr_req_t         mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while count says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// rtl/rf_write_scheduler.sv - register-file write-port arbiter with MDU busy scoreboard
//
// Purpose: shares the single RF write port between the writeback stage
// (strict priority, no backpressure) and buffered MDU results, tracks
// registers awaiting MDU results and stalls decode on hazards.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   wb_valid/addr/data        writeback write request
//   mdu_if (slave)            MDU result handshake
//   iss_valid/iss_dest        MDU instruction issued, its destination
//   dec_rs/dec_rt/dec_rd      decode operands (0 = unused)
//   dec_stall                 hazard stall to decode
//   rf_regwrite/writereg/writedata  RF write port
//   busy_vec                  per-register pending flags
//   fifo_count                buffered MDU results
module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int DATA_W     = rf_sched_pkg::DATA_W,
  parameter int ADDR_W     = rf_sched_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_valid,
  input  logic [ADDR_W-1:0]           wb_addr,
  input  logic [DATA_W-1:0]           wb_data,
  rf_write_scheduler_if.slave         mdu_if,
  input  logic                        iss_valid,
  input  logic [ADDR_W-1:0]           iss_dest,
  input  logic [ADDR_W-1:0]           dec_rs,
  input  logic [ADDR_W-1:0]           dec_rt,
  input  logic [ADDR_W-1:0]           dec_rd,
  output logic                        dec_stall,
  output logic                        rf_regwrite,
  output logic [ADDR_W-1:0]           rf_writereg,
  output logic [DATA_W-1:0]           rf_writedata,
  output logic [2**ADDR_W-1:0]        busy_vec,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int NREG = 2**ADDR_W;

  wr_req_t         fifo_head;
  wr_req_t         fifo_in;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic            mdu_ready_w;
  logic            wb_wr;
  logic [NREG-1:0] busy_q, busy_d;

  // Ready follows the current count; a pop in a full cycle does not reopen it.
  assign mdu_ready_w      = !rst && !fifo_full;
  assign mdu_if.mdu_ready = mdu_ready_w;

  // $0 results are consumed by the handshake but never stored.
  assign fifo_push = mdu_if.mdu_valid && mdu_ready_w && (mdu_if.mdu_addr != ZERO_REG);
  assign fifo_in   = '{addr: mdu_if.mdu_addr, data: mdu_if.mdu_data};

  rf_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (fifo_in),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // WB writes to $0 do not occupy the port, letting the FIFO head through.
  assign wb_wr = wb_valid && (wb_addr != ZERO_REG);

  always_comb begin
    rf_regwrite  = 1'b0;
    rf_writereg  = '0;
    rf_writedata = '0;
    fifo_pop     = 1'b0;
    if (!rst) begin
      if (wb_wr) begin
        rf_regwrite  = 1'b1;
        rf_writereg  = wb_addr;
        rf_writedata = wb_data;
      end else if (!fifo_empty) begin
        rf_regwrite  = 1'b1;
        rf_writereg  = fifo_head.addr;
        rf_writedata = fifo_head.data;
        fifo_pop     = 1'b1;
      end
    end
  end

  // Clear on the RF write of the head, then apply the issue set so that a
  // same-cycle set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop) busy_d[fifo_head.addr] = 1'b0;
    if (iss_valid && (iss_dest != ZERO_REG)) busy_d[iss_dest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec  = busy_q;
  assign dec_stall = busy_q[dec_rs] | busy_q[dec_rt] | busy_q[dec_rd];

endmodule

// File: tb/tb_rf_write_scheduler.sv
// tb/tb_rf_write_scheduler.sv - self-checking bench for rf_write_scheduler
module tb_rf_write_scheduler;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          iss_valid = 1'b0;
  logic [AW-1:0] iss_dest = '0;
  logic [AW-1:0] dec_rs = '0, dec_rt = '0, dec_rd = '0;
  logic          dec_stall;
  logic          rf_regwrite;
  logic [AW-1:0] rf_writereg;
  logic [DW-1:0] rf_writedata;
  logic [31:0]   busy_vec;
  logic [1:0]    fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  exp_wr_t wb_q[$];
  exp_wr_t mdu_q[$];

  rf_write_scheduler_if #(.DATA_W(DW), .ADDR_W(AW)) mif ();

  rf_write_scheduler #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .mdu_if       (mif),
    .iss_valid    (iss_valid),
    .iss_dest     (iss_dest),
    .dec_rs       (dec_rs),
    .dec_rt       (dec_rt),
    .dec_rd       (dec_rd),
    .dec_stall    (dec_stall),
    .rf_regwrite  (rf_regwrite),
    .rf_writereg  (rf_writereg),
    .rf_writedata (rf_writedata),
    .busy_vec     (busy_vec),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_wr_t e;
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
    if (v && a != '0) begin
      e.addr = a;
      e.data = d;
      wb_q.push_back(e);
    end
  endtask

  task automatic drive_mdu(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mif.mdu_valid = v;
    mif.mdu_addr  = a;
    mif.mdu_data  = d;
  endtask

  // Scoreboard: WB writes take the port whenever present; otherwise a
  // pending MDU result must be written. Accepted MDU results are queued here.
  always @(negedge clk) begin
    exp_wr_t e;
    if (!rst) begin
      if (wb_valid && wb_addr != '0) begin
        if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
        else begin
          e = wb_q.pop_front();
          chk("wb_regwrite", rf_regwrite, 1);
          chk("wb_writereg", rf_writereg, e.addr);
          chk("wb_writedata", rf_writedata, e.data);
        end
      end else if (mdu_q.size() != 0) begin
        e = mdu_q.pop_front();
        chk("mdu_regwrite", rf_regwrite, 1);
        chk("mdu_writereg", rf_writereg, e.addr);
        chk("mdu_writedata", rf_writedata, e.data);
      end else if (rf_regwrite) begin
        chk("spurious_write", rf_regwrite, 0);
      end
      if (mif.mdu_valid && mif.mdu_ready && mif.mdu_addr != '0) begin
        e.addr = mif.mdu_addr;
        e.data = mif.mdu_data;
        mdu_q.push_back(e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    drive_mdu(0, '0, '0);

    // Reset and idle
    nxt();
    chk("rst_ready", mif.mdu_ready, 0);
    chk("rst_regwrite", rf_regwrite, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy_vec, 0);
    rst = 1'b0;
    #1;
    chk("rel_ready", mif.mdu_ready, 1);
    chk("rel_writereg", rf_writereg, 0);
    chk("rel_writedata", rf_writedata, 0);
    nxt();
    chk("idle_busy", busy_vec, 0);
    chk("idle_stall", dec_stall, 0);

    // Issue to $8, result 3 cycles later, no WB
    iss_valid = 1; iss_dest = 5'd8;
    nxt();
    iss_valid = 0; dec_rs = 5'd8;
    #2 chk("iss_stall_1", dec_stall, 1);
    chk("iss_busy8", busy_vec[8], 1);
    nxt(); chk("iss_stall_2", dec_stall, 1);
    nxt(); chk("iss_stall_3", dec_stall, 1);
    nxt();
    drive_mdu(1, 5'd8, 32'hDEADBEEF);
    #2 chk("mdu8_ready", mif.mdu_ready, 1);
    chk("mdu8_nowrite", rf_regwrite, 0);
    chk("mdu8_stall", dec_stall, 1);
    nxt();
    drive_mdu(0, '0, '0);
    #2 chk("mdu8_count", fifo_count, 1);
    chk("mdu8_wr", rf_regwrite, 1);
    chk("mdu8_addr", rf_writereg, 8);
    chk("mdu8_data", rf_writedata, 32'hDEADBEEF);
    chk("mdu8_stall_wr", dec_stall, 1);
    nxt();
    chk("mdu8_done_wr", rf_regwrite, 0);
    chk("mdu8_busy_clr", busy_vec, 0);
    chk("mdu8_unstall", dec_stall, 0);
    chk("mdu8_count0", fifo_count, 0);
    dec_rs = '0;

    // WB streak with two MDU results arriving
    iss_valid = 1; iss_dest = 5'd9;  nxt();
    iss_valid = 1; iss_dest = 5'd10; nxt();
    iss_valid = 0;
    for (int i = 0; i < 6; i++) begin
      drive_wb(1, 5'd3, 32'h100 + i);
      if (i == 0) drive_mdu(1, 5'd9, 32'h99);
      else if (i == 1) drive_mdu(1, 5'd10, 32'hAA);
      else drive_mdu(0, '0, '0);
      #2;
      if (i < 2) chk("streak_ready", mif.mdu_ready, 1);
      else begin
        chk("streak_full_ready", mif.mdu_ready, 0);
        chk("streak_count", fifo_count, 2);
      end
      chk("streak_wreg", rf_writereg, 3);
      nxt();
    end
    drive_wb(0, '0, '0);
    #2 chk("drain9_addr", rf_writereg, 9);
    chk("drain9_data", rf_writedata, 32'h99);
    nxt();
    chk("drain10_addr", rf_writereg, 10);
    chk("drain10_count", fifo_count, 1);
    nxt();
    chk("drain_idle", rf_regwrite, 0);
    chk("drain_count", fifo_count, 0);
    chk("drain_busy", busy_vec, 0);

    // WB to $0 alongside a buffered result
    drive_wb(1, 5'd4, 32'h44);
    drive_mdu(1, 5'd12, 32'h12);
    nxt();
    drive_mdu(0, '0, '0);
    drive_wb(1, 5'd0, 32'h55);
    #2 chk("z_wr", rf_regwrite, 1);
    chk("z_addr", rf_writereg, 12);
    chk("z_data", rf_writedata, 32'h12);
    nxt();
    drive_wb(0, '0, '0);
    #2 chk("z_idle", rf_regwrite, 0);
    chk("z_count", fifo_count, 0);

    // MDU result to $0 is discarded
    drive_mdu(1, 5'd0, 32'h77);
    #2 chk("m0_ready", mif.mdu_ready, 1);
    nxt();
    drive_mdu(0, '0, '0);
    #2 chk("m0_count", fifo_count, 0);
    chk("m0_nowrite", rf_regwrite, 0);

    // Same-cycle set and clear of $6
    iss_valid = 1; iss_dest = 5'd6; nxt();
    iss_valid = 0;
    drive_wb(1, 5'd2, 32'h22);
    drive_mdu(1, 5'd6, 32'h66);
    nxt();
    drive_mdu(0, '0, '0);
    drive_wb(0, '0, '0);
    iss_valid = 1; iss_dest = 5'd6;
    #2 chk("sc_wreg", rf_writereg, 6);
    nxt();
    iss_valid = 0;
    chk("sc_busy6", busy_vec[6], 1);
    chk("sc_count", fifo_count, 0);

    // Reset with two buffered entries and busy[5]
    drive_wb(1, 5'd2, 32'h30);
    drive_mdu(1, 5'd5, 32'h55);
    iss_valid = 1; iss_dest = 5'd5;
    nxt();
    iss_valid = 0;
    drive_wb(1, 5'd2, 32'h31);
    drive_mdu(1, 5'd7, 32'h777);
    nxt();
    drive_mdu(0, '0, '0);
    drive_wb(1, 5'd2, 32'h32);
    #1 chk("pre_rst_count", fifo_count, 2);
    chk("pre_rst_busy5", busy_vec[5], 1);
    #1;
    rst = 1'b1;
    wb_valid = 1'b0;
    wb_q.delete();
    mdu_q.delete();
    #1 chk("arst_count", fifo_count, 0);
    chk("arst_busy", busy_vec, 0);
    chk("arst_regwrite", rf_regwrite, 0);
    chk("arst_ready", mif.mdu_ready, 0);
    nxt();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2 chk("post_rst_nowrite", rf_regwrite, 0);
      chk("post_rst_count", fifo_count, 0);
      nxt();
    end

    chk("wbq_empty", wb_q.size(), 0);
    chk("mduq_empty", mdu_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
